core_mem_arbiter: RTL

Shares one single-port memory between the instruction fetch stage and the memory stage of the 5-stage core. Each side issues one request at a time and receives a grant and a later response over a request/grant/response handshake. Only one transaction is outstanding at a time. The block tracks which side owns it, routes the memory response back to that owner, and drops fetch responses on a branch flush. It also flags a hung memory with a sticky timeout error.

---
 rtl/core_mem_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
//
// Shares one single-port memory between the instruction fetch stage (if_*)
// and the memory stage (dm_*). Only one transaction is outstanding at a time.
// The block records which side owns the transaction and routes the memory
// response back to that side. It drops a fetch response when a branch flush
// is seen while the fetch is outstanding. If memory never answers, it raises
// a sticky timeout error.
//
// Handshake (valid/ready semantics, all sides):
//   A requester holds *_req_i and its command stable until *_gnt_o is high in
//   the same cycle. Grants are issued only in IDLE, combinationally from the
//   requests. mem_req_o pulses for exactly that grant cycle, with the command
//   on mem_*_o. The memory answers later with a single-cycle mem_rvalid_i.
//   That pulse is forwarded in the same cycle as the owner's *_rvalid_o, with
//   *_rdata_o passing mem_rdata_i through. rdata is don't-care while rvalid
//   is low.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   if_req_i/if_addr_i      fetch read request
//   if_gnt_o/if_rvalid_o/if_rdata_o   fetch grant and response
//   dm_req_i/dm_we_i/dm_be_i/dm_addr_i/dm_wdata_i   data request
//   dm_gnt_o/dm_rvalid_o/dm_rdata_o   data grant and response (stores ack)
//   flush_i                 branch redirect; blocks and kills fetches
//   mem_req_o/mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o   memory command
//   mem_rvalid_i/mem_rdata_i          memory response
//   busy_o                  a transaction is outstanding (state == WAIT)
//   err_o                   sticky timeout error
//   dbg_state_o             current FSM state (0 = IDLE, 1 = WAIT)
//
// Optional feature: define CORE_ARB_STARVE_GUARD_EN to add a starvation guard.
// After STARVE_MAX consecutive dm grants that denied an eligible fetch, the
// guard forces the next eligible fetch to win. Without the macro, priority is
// strictly dm-first.

module core_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [3:0]        dm_be_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              err_o,
    output logic              dbg_state_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state_q, state_n;
    owner_t          owner_q, owner_n;
    logic [TO_W-1:0] to_cnt_q, to_cnt_n;
    logic            kill_q, kill_n;
    logic            err_q, err_n;

    logic            if_elig;
    logic            force_if;
    logic            grant_if, grant_dm;
    logic            in_idle, in_wait;

    assign in_idle = (state_q == ST_IDLE);
    assign in_wait = (state_q == ST_WAIT);

    // A fetch presented together with a flush is on the wrong path.
    assign if_elig = if_req_i & ~flush_i;

`ifdef CORE_ARB_STARVE_GUARD_EN
    localparam int SV_W = $clog2(STARVE_MAX + 1);
    localparam logic [SV_W-1:0] SV_MAX = SV_W'(STARVE_MAX);

    logic [SV_W-1:0] starve_q, starve_n;

    assign force_if = (starve_q >= SV_MAX);

    always_comb begin
        starve_n = starve_q;
        if (grant_if) begin
            starve_n = '0;
        end else if (grant_dm && if_elig && (starve_q < SV_MAX)) begin
            starve_n = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) starve_q <= '0;
        else       starve_q <= starve_n;
    end
`else
    // Strict dm-first priority. STARVE_MAX is a non-negative count, so this
    // is a constant 0. The expression only keeps the parameter referenced.
    assign force_if = (STARVE_MAX < 0);
`endif

    // The grant gates force every grant low while reset is asserted.
    assign grant_if = in_idle & ~rst_i & if_elig & (~dm_req_i | force_if);
    assign grant_dm = in_idle & ~rst_i & dm_req_i & ~(force_if & if_elig);

    assign if_gnt_o  = grant_if;
    assign dm_gnt_o  = grant_dm;
    assign mem_req_o = grant_if | grant_dm;

    // The command follows the winner. When nobody is granted it is don't-care.
    always_comb begin
        mem_we_o    = dm_we_i;
        mem_be_o    = dm_be_i;
        mem_addr_o  = dm_addr_i;
        mem_wdata_o = dm_wdata_i;
        if (grant_if) begin
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_addr_o  = if_addr_i;
            mem_wdata_o = '0;
        end
    end

    // A flush in the response cycle itself also kills the fetch response,
    // which is why flush_i is checked here as well as kill_q.
    assign if_rvalid_o = in_wait & ~rst_i & mem_rvalid_i & (owner_q == OWN_IF)
                         & ~kill_q & ~flush_i;
    assign dm_rvalid_o = in_wait & ~rst_i & mem_rvalid_i & (owner_q == OWN_DM);
    assign if_rdata_o  = mem_rdata_i;
    assign dm_rdata_o  = mem_rdata_i;

    assign busy_o      = in_wait;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

    // Next-state logic. A response in the last counted cycle beats the timeout.
    always_comb begin
        state_n  = state_q;
        owner_n  = owner_q;
        to_cnt_n = to_cnt_q;
        kill_n   = kill_q;
        err_n    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_if || grant_dm) begin
                    state_n  = ST_WAIT;
                    owner_n  = grant_dm ? OWN_DM : OWN_IF;
                    to_cnt_n = '0;
                    kill_n   = 1'b0;
                end
            end
            ST_WAIT: begin
                if ((owner_q == OWN_IF) && flush_i) kill_n = 1'b1;
                if (mem_rvalid_i) begin
                    state_n = ST_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b1;
                end else begin
                    to_cnt_n = to_cnt_q + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IF;
            to_cnt_q <= '0;
            kill_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            owner_q  <= owner_n;
            to_cnt_q <= to_cnt_n;
            kill_q   <= kill_n;
            err_q    <= err_n;
        end
    end

endmodule
